comparator_unit: RTL
====================

// Module: comparator_unit
// PURPOSE
//  Pipelined, parametrised integer compare unit for the ALU compare/branch path.
//  Generalises the single-bit signed-LT derivation to all RV64 compare flavours:
//  SLT, SLTU, EQ, NE, GE, GEU, MIN, MAX, MINU and MAXU.
//  It uses two register stages with valid/ready backpressure and a tag that passes through unchanged.
//  It sits between the operand-read stage and the writeback/branch-resolve logic.
// PARAMETERS
//  WIDTH   64  operand width in bits (>=2)
//  TAG_W   5   width of the opaque tag (e.g. destination register index)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  flush      in   1        synchronous kill of all in-flight ops
//  in_valid   in   1        operand/op presented
//  in_ready   out  1        unit accepts the op this cycle
//  in_op      in   4        compare op (encoding in cmp_pkg)
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_tag     in   TAG_W    tag, returned with the result
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts the result
//  out_res    out  WIDTH    result: flag zero-extended to WIDTH, or the selected operand
//  out_flag   out  1        raw compare bit; for MIN/MAX = 1 when A was selected
//  out_tag    out  TAG_W    tag of the result
// BEHAVIOUR
//  Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_flag=0, out_tag=0.
//    in_ready=1 as soon as reset releases.
//  Handshake: a transfer occurs when valid&ready are both high on a rising edge.
//    The producer holds in_* stable while in_valid=1 and in_ready=0.
//  Stage 1 (S1), on accept, registers:
//    - op, tag, a, b
//    - sign bits A_S=a[W-1], B_S=b[W-1]
//    - diff=a-b over WIDTH+1 bits; S_S=diff[W-1]; BORROW=diff[W]
//    - EQ=(a==b)
//  Stage 2 (S2), on advance from S1, computes and registers the result:
//    - LT_S = (A_S&~B_S) | ((~EQ&S_S) & (~B_S|A_S))
//    - LT_U = BORROW
//    - SLT:LT_S  SLTU:LT_U  EQ:EQ  NE:~EQ  GE:~LT_S  GEU:~LT_U
//    - MIN:LT_S?a:b  MAX:LT_S?b:a  MINU:LT_U?a:b  MAXU:LT_U?b:a
//    - With a==b, MIN/MAX select a, so out_flag=1.
//    - Undefined op codes produce out_res=0 and out_flag=0. They still flow and still hand shake.
//  Stall rules:
//    - s2_adv = ~s2_valid | out_ready
//    - s1_adv = ~s1_valid | s2_adv
//    - in_ready = s1_adv, combinational; no combinational path from in_valid.
//  Latency is 2 cycles from accept to out_valid. Throughput is 1 op/cycle when out_ready stays 1.
//  Backpressure: with out_ready=0, S2 holds and S1 fills. in_ready then falls the next cycle.
//    No data is lost or duplicated, and out_* stay stable while out_valid=1 and out_ready=0.
//  Simultaneous events: when S2 is consumed and S1 refills in the same edge, both moves happen.
//  Flush:
//    - Clears s1_valid and s2_valid on the next edge. Operand data registers may keep stale values.
//    - in_ready=0 during the flush cycle, and an in_valid on that cycle is NOT accepted.
//    - flush overrides everything else.
//  Reset mid-operation drops all in-flight ops immediately (async).
//  Width rules:
//    - The subtract is WIDTH+1 bits, zero-extended.
//    - The boolean result is {WIDTH-1 zeros, flag}.
//    - No overflow flag is exported. The LT_S expression already covers mixed-sign overflow.
// STRUCTURE
//  cmp_pkg (shared package):
//    - localparams for the op encodings: SLT=0 SLTU=1 EQ=2 NE=3 GE=4 GEU=5 MIN=6 MAX=7 MINU=8 MAXU=9
//    - CMP_OP_W=4
//  Sub-module cmp_flags:
//    - combinational: a, b -> A_S, B_S, S_S, BORROW, EQ
//    - instanced in S1; reused by the FP compare path later
//  Top holds the two pipeline registers, the stall/flush control and the S2 op decode.
// TESTING  (WIDTH=8 unless noted)
//  1. SLT a=8'h80 b=8'h7F, out_ready=1 -> 2 cycles later out_res=1, out_flag=1.
//     SLTU on the same operands -> out_res=0.
//  2. Back-to-back: MIN(-3,5), MAXU(8'hFF,8'h01), EQ(7,7), one per cycle.
//     -> consecutive out_res 8'hFD, 8'hFF, 1 with matching tags, in_ready stays 1.
//  3. out_ready=0 for 4 cycles with 3 ops offered:
//     -> in_ready falls after 2 accepts and out_* hold stable.
//     -> on release, results drain in order with no loss or duplicate.
//  4. Hold out_ready=0 to fill both stages, then assert flush -> next cycle out_valid=0, in_ready=1.
//     -> a new op issued afterwards returns correctly after 2 cycles.
//  5. rst_n low mid-stream (async, between edges) -> out_valid=0 and out_res=0 immediately.
//     -> no stale result appears after release.
//  6. WIDTH=64 random signed/unsigned sweep vs a reference model (>=10k ops), including:
//     - the edge values 0, -1, INT_MIN and INT_MAX
//     - a==b
//     - an undefined op=15, which must return out_res=0

Source files
------------

// File: rtl/comparator_unit_pkg.sv
// Shared definitions for the integer compare unit.
// Op encodings are also used by the decode stage.
package cmp_pkg;

    localparam int CMP_OP_W = 4;

    localparam logic [CMP_OP_W-1:0] OP_SLT  = 4'd0;
    localparam logic [CMP_OP_W-1:0] OP_SLTU = 4'd1;
    localparam logic [CMP_OP_W-1:0] OP_EQ   = 4'd2;
    localparam logic [CMP_OP_W-1:0] OP_NE   = 4'd3;
    localparam logic [CMP_OP_W-1:0] OP_GE   = 4'd4;
    localparam logic [CMP_OP_W-1:0] OP_GEU  = 4'd5;
    localparam logic [CMP_OP_W-1:0] OP_MIN  = 4'd6;
    localparam logic [CMP_OP_W-1:0] OP_MAX  = 4'd7;
    localparam logic [CMP_OP_W-1:0] OP_MINU = 4'd8;
    localparam logic [CMP_OP_W-1:0] OP_MAXU = 4'd9;

endpackage

// File: rtl/comparator_unit_if.sv
// Operand-in / result-out handshake bundle of the compare unit.
// master = producer/consumer side, slave = the unit itself.
interface comparator_unit_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) ();

    logic                in_valid;
    logic                in_ready;
    logic [CMP_OP_W-1:0] in_op;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic [TAG_W-1:0]    in_tag;

    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_res;
    logic                out_flag;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid, out_res, out_flag, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  out_ready,
        output in_ready,
        output out_valid, out_res, out_flag, out_tag
    );

endinterface

// File: rtl/comparator_unit_flags.sv
// Raw compare flags of two operands (sign bits, subtract, equality).
// Purely combinational so the FP compare path can reuse it.
module cmp_flags #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_as,
    output logic             o_bs,
    output logic             o_ss,
    output logic             o_borrow,
    output logic             o_eq
);

    logic [WIDTH:0] w_diff;

    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign o_as     = i_a[WIDTH-1];
    assign o_bs     = i_b[WIDTH-1];
    assign o_ss     = w_diff[WIDTH-1];
    assign o_borrow = w_diff[WIDTH];
    // low WIDTH bits of a-b are zero exactly when a == b
    assign o_eq     = ~|w_diff[WIDTH-1:0];

endmodule

// File: rtl/comparator_unit.sv
// Two-stage pipelined integer compare unit (SLT..MAXU) with
// valid/ready backpressure, synchronous flush and pass-through tag.
module comparator_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    comparator_unit_if.slave  bus
);

    logic                r_s1_valid;
    logic [CMP_OP_W-1:0] r_s1_op;
    logic [TAG_W-1:0]    r_s1_tag;
    logic [WIDTH-1:0]    r_s1_a;
    logic [WIDTH-1:0]    r_s1_b;
    logic                r_s1_as;
    logic                r_s1_bs;
    logic                r_s1_ss;
    logic                r_s1_borrow;
    logic                r_s1_eq;

    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_s2_res;
    logic                r_s2_flag;
    logic [TAG_W-1:0]    r_s2_tag;

    logic w_as, w_bs, w_ss, w_borrow, w_eq;
    logic w_s2_adv, w_s1_adv, w_acc, w_mv;
    logic w_lt_s, w_lt_u, w_flag, w_bool;
    logic [WIDTH-1:0] w_res;

    cmp_flags #(.WIDTH(WIDTH)) u_flags (
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .o_as     (w_as),
        .o_bs     (w_bs),
        .o_ss     (w_ss),
        .o_borrow (w_borrow),
        .o_eq     (w_eq)
    );

    assign w_s2_adv = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign w_acc    = bus.in_valid & w_s1_adv & ~flush;
    assign w_mv     = r_s1_valid & w_s2_adv & ~flush;

    assign bus.in_ready  = w_s1_adv & ~flush;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_res   = r_s2_res;
    assign bus.out_flag  = r_s2_flag;
    assign bus.out_tag   = r_s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) r_s1_valid <= bus.in_valid;
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_op     <= '0;
            r_s1_tag    <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_as     <= 1'b0;
            r_s1_bs     <= 1'b0;
            r_s1_ss     <= 1'b0;
            r_s1_borrow <= 1'b0;
            r_s1_eq     <= 1'b0;
        end else if (w_acc) begin
            r_s1_op     <= bus.in_op;
            r_s1_tag    <= bus.in_tag;
            r_s1_a      <= bus.in_a;
            r_s1_b      <= bus.in_b;
            r_s1_as     <= w_as;
            r_s1_bs     <= w_bs;
            r_s1_ss     <= w_ss;
            r_s1_borrow <= w_borrow;
            r_s1_eq     <= w_eq;
        end
    end

    // mixed-sign operands are resolved by the sign bits alone
    assign w_lt_s = (r_s1_as & ~r_s1_bs)
                  | ((~r_s1_eq & r_s1_ss) & (~r_s1_bs | r_s1_as));
    assign w_lt_u = r_s1_borrow;

    always_comb begin
        w_flag = 1'b0;
        w_bool = 1'b1;
        w_res  = '0;
        case (r_s1_op)
            OP_SLT:  w_flag = w_lt_s;
            OP_SLTU: w_flag = w_lt_u;
            OP_EQ:   w_flag = r_s1_eq;
            OP_NE:   w_flag = ~r_s1_eq;
            OP_GE:   w_flag = ~w_lt_s;
            OP_GEU:  w_flag = ~w_lt_u;
            OP_MIN:  begin w_flag = w_lt_s | r_s1_eq; w_bool = 1'b0; end
            OP_MAX:  begin w_flag = ~w_lt_s;          w_bool = 1'b0; end
            OP_MINU: begin w_flag = w_lt_u | r_s1_eq; w_bool = 1'b0; end
            OP_MAXU: begin w_flag = ~w_lt_u;          w_bool = 1'b0; end
            default: begin w_flag = 1'b0;             w_bool = 1'b1; end
        endcase
        if (w_bool) w_res = {{(WIDTH-1){1'b0}}, w_flag};
        else        w_res = w_flag ? r_s1_a : r_s1_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_res  <= '0;
            r_s2_flag <= 1'b0;
            r_s2_tag  <= '0;
        end else if (w_mv) begin
            r_s2_res  <= w_res;
            r_s2_flag <= w_flag;
            r_s2_tag  <= r_s1_tag;
        end
    end

endmodule
